// File: rtl/ifetch.sv
// Instruction-fetch stage: loads IF/ID register, issues control-transfer shadow bubbles, freezes on halt.
// Optional IFETCH_PERF_EN adds fetch_cnt/bubble_cnt performance counters.
module ifetch #(
    parameter int unsigned SHADOW  = 3,
    parameter logic [31:0] NOP_INS = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'd63
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic [31:0] pc_in,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins_d,
    output logic [5:0]  op_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
`ifdef IFETCH_PERF_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt,
`endif
    output logic        halted
);

    localparam int unsigned SH = (SHADOW == 0) ? 1 : SHADOW;
    localparam int CW = $clog2(SH + 1);

    typedef enum logic [1:0] {
        RUN,
        SHAD,
        HALT
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0]   ins_nx;
    logic [31:0]   pc_nx;
    logic          vld_nx;
    logic          halt_nx;
    logic [5:0]    op_f;
    logic          is_ctrl;

    assign imem_addr = pc_in;
    assign op_f      = imem_rdata[31:26];
    assign op_d      = ins_d[31:26];

    always_comb begin
        is_ctrl = 1'b0;
        case (op_f)
            6'd32, 6'd33, 6'd34, 6'd35,
            6'd40, 6'd41, 6'd42: is_ctrl = 1'b1;
            default:             is_ctrl = 1'b0;
        endcase
    end

    // Anything other than a RUN fetch loads a bubble.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ins_nx   = NOP_INS;
        pc_nx    = '0;
        vld_nx   = 1'b0;
        halt_nx  = halted;
        unique case (state)
            RUN: begin
                ins_nx = imem_rdata;
                pc_nx  = pc_in + 32'd1;
                vld_nx = 1'b1;
                if (is_ctrl) begin
                    state_nx = SHAD;
                    cnt_nx   = CW'(SH);
                end else if (op_f == HALT_OP) begin
                    state_nx = HALT;
                    halt_nx  = 1'b1;
                end
            end
            SHAD: begin
                if (cnt <= CW'(1)) begin
                    cnt_nx   = '0;
                    state_nx = RUN;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            HALT: begin
                halt_nx = 1'b1;
            end
            default: begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state   <= RUN;
            cnt     <= '0;
            ins_d   <= NOP_INS;
            pc_d    <= '0;
            valid_d <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ins_d   <= ins_nx;
            pc_d    <= pc_nx;
            valid_d <= vld_nx;
            halted  <= halt_nx;
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            fetch_cnt  <= fetch_cnt + 32'(vld_nx);
            bubble_cnt <= bubble_cnt + 32'(!vld_nx);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed vector table, hand sequences, and
// randomized traffic against a shadow/halt reference model.
module tb_ifetch;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam int          SHD = 3;

    logic        clk = 1'b0;
    logic        rstd;
    logic [31:0] pc_in;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr, ins_d, pc_d;
    logic [5:0]  op_d;
    logic        valid_d, halted;
    logic [31:0] s0_addr, s0_ins, s0_pc;
    logic [5:0]  s0_op;
    logic        s0_valid, s0_halted;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt, bubble_cnt, s0_fc, s0_bc;
`endif

    always #5 clk = ~clk;

    ifetch #(.SHADOW(SHD)) dut (
        .clk(clk), .rstd(rstd), .pc_in(pc_in),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ins_d(ins_d), .op_d(op_d), .pc_d(pc_d),
        .valid_d(valid_d),
`ifdef IFETCH_PERF_EN
        .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt),
`endif
        .halted(halted)
    );

    ifetch #(.SHADOW(0)) u_s0 (
        .clk(clk), .rstd(rstd), .pc_in(pc_in),
        .imem_addr(s0_addr), .imem_rdata(imem_rdata),
        .ins_d(s0_ins), .op_d(s0_op), .pc_d(s0_pc),
        .valid_d(s0_valid),
`ifdef IFETCH_PERF_EN
        .fetch_cnt(s0_fc), .bubble_cnt(s0_bc),
`endif
        .halted(s0_halted)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] ins;
        logic [31:0] pcd;
        logic        v;
        logic        h;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nmis = 0;

    int          m_left;
    bit          m_halt;
    logic [31:0] m_ins, m_pc;
    logic        m_v;
    int unsigned m_fc, m_bc;

    function automatic bit is_ctrl(input logic [5:0] op);
        return op inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd40, 6'd41, 6'd42};
    endfunction

    function automatic logic [103:0] pack(input logic [31:0] a, input logic [31:0] i,
                                          input logic [31:0] p, input logic v,
                                          input logic h);
        logic [31:0] t;
        t = i;
        return {a, i, t[31:26], p, v, h};
    endfunction

    task automatic chk(input string nm, input logic [103:0] got, input logic [103:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [103:0] dut_out();
        return {imem_addr, ins_d, op_d, pc_d, valid_d, halted};
    endfunction

    task automatic model_reset();
        m_left = 0; m_halt = 0; m_fc = 0; m_bc = 0;
        m_ins = NOP; m_pc = 0; m_v = 0;
    endtask

    task automatic model_edge(input logic [31:0] pc, input logic [31:0] w);
        logic [5:0] op;
        if (m_halt || m_left > 0) begin
            m_ins = NOP; m_pc = 0; m_v = 0;
            if (m_left > 0) m_left--;
            m_bc++;
        end else begin
            m_ins = w; m_pc = pc + 32'd1; m_v = 1;
            m_fc++;
            op = w[31:26];
            if (is_ctrl(op)) m_left = SHD;
            else if (op == 6'd63) m_halt = 1;
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] w);
        pc_in = pc;
        imem_rdata = w;
        @(posedge clk);
        #1;
        model_edge(pc, w);
    endtask

    // Called 1 time unit after a rising edge; resets mid-cycle.
    task automatic mid_reset(input string nm);
        #2 rstd = 1'b0;
        #1;
        model_reset();
        chk(nm, dut_out(), pack(pc_in, NOP, 32'd0, 1'b0, 1'b0));
        #2 rstd = 1'b1;
    endtask

    task automatic add(input logic [31:0] pc, input logic [31:0] w,
                       input logic [31:0] i, input logic [31:0] p,
                       input logic v, input logic h);
        vec_t e;
        e.pc = pc; e.word = w; e.ins = i; e.pcd = p; e.v = v; e.h = h;
        tbl.push_back(e);
    endtask

    initial begin
        logic [5:0]  ops[7];
        logic [5:0]  op;
        logic [31:0] r, w, pc;
        int          k;

        ops = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd40, 6'd41, 6'd42};
        rstd = 1'b0;
        pc_in = 0;
        imem_rdata = 0;
        model_reset();

        add(0,  32'h0C000005, 32'h0C000005, 1,  1, 0);
        add(1,  32'h08000002, 32'h08000002, 2,  1, 0);
        add(2,  32'h10000003, 32'h10000003, 3,  1, 0);
        add(3,  32'h14000004, 32'h14000004, 4,  1, 0);
        add(4,  32'h18000005, 32'h18000005, 5,  1, 0);
        add(7,  32'h80000010, 32'h80000010, 8,  1, 0);
        add(8,  32'hDEADBEEF, NOP,          0,  0, 0);
        add(8,  32'h04000001, NOP,          0,  0, 0);
        add(8,  32'hA0000040, NOP,          0,  0, 0);
        add(20, 32'h20000014, 32'h20000014, 21, 1, 0);
        add(21, 32'hA0000030, 32'hA0000030, 22, 1, 0);
        add(22, 32'hA0000040, NOP,          0,  0, 0);
        add(22, 32'h84000000, NOP,          0,  0, 0);
        add(22, 32'h0C000001, NOP,          0,  0, 0);
        add(48, 32'hA0000050, 32'hA0000050, 49, 1, 0);
        add(49, 32'hFC000000, NOP,          0,  0, 0);
        add(49, 32'h12345678, NOP,          0,  0, 0);
        add(49, 32'hA8000000, NOP,          0,  0, 0);
        add(80, 32'h24000001, 32'h24000001, 81, 1, 0);
        add(12, 32'hFC000000, 32'hFC000000, 13, 1, 1);
        for (int i = 0; i < 11; i++)
            add(13 + i, 32'h01000000 * (i + 1) + 32'h5, NOP, 0, 0, 1);

        // Reset mid-cycle from a loaded state
        #12;
        chk("reset_initial", dut_out(), pack(pc_in, NOP, 0, 0, 0));
        rstd = 1'b1;
        drive(3, 32'h12345678);
        chk("pre_reset_load", dut_out(), pack(3, 32'h12345678, 4, 1, 0));
        mid_reset("async_reset");

        foreach (tbl[i]) begin
            drive(tbl[i].pc, tbl[i].word);
            chk($sformatf("vec%0d", i), dut_out(),
                pack(tbl[i].pc, tbl[i].ins, tbl[i].pcd, tbl[i].v, tbl[i].h));
        end
        mid_reset("halt_cleared_by_reset");

        // SHADOW=0 behaves as a single bubble
        drive(5, 32'h8C000000);
        chk("s0_ctrl", {s0_ins, s0_pc, 8'(s0_valid)}, {32'h8C000000, 32'd6, 8'd1});
        drive(6, 32'h04000009);
        chk("s0_bubble", {s0_ins, s0_pc, 8'(s0_valid)}, {NOP, 32'd0, 8'd0});
        drive(40, 32'h0400000A);
        chk("s0_target", {s0_ins, s0_pc, 8'(s0_valid)}, {32'h0400000A, 32'd41, 8'd1});
        drive(41, 32'h0400000B);
        mid_reset("reset_before_perf");

        // pc wraps at 2^32
        drive(32'hFFFF_FFFF, 32'h04000000);
        chk("pc_wrap", dut_out(), pack(32'hFFFF_FFFF, 32'h04000000, 0, 1, 0));

`ifdef IFETCH_PERF_EN
        mid_reset("reset_perf");
        for (int i = 0; i < 4; i++) drive(i, 32'h04000000 + i);
        drive(4, 32'h80000002);
        for (int i = 0; i < 3; i++) drive(5, 32'h04000099);
        drive(9, 32'h04000001);
        drive(10, 32'h04000002);
        chk("perf_counts", {40'd0, fetch_cnt, bubble_cnt}, {40'd0, 32'd7, 32'd3});
`endif

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 99);
            if (k < 25) op = ops[$urandom_range(0, 6)];
            else if (k < 27) op = 6'd63;
            else op = 6'($urandom_range(0, 62));
            r = $urandom();
            w = {op, r[25:0]};
            pc = $urandom();
            drive(pc, w);
            chk($sformatf("rnd%0d", n), dut_out(), pack(pc, m_ins, m_pc, m_v, m_halt));
`ifdef IFETCH_PERF_EN
            chk($sformatf("rnd_perf%0d", n), {40'd0, fetch_cnt, bubble_cnt},
                {40'd0, m_fc, m_bc});
`endif
            if ($urandom_range(0, 99) < 4) mid_reset($sformatf("rnd_reset%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
